// File: rtl/mux_n_1_stream.sv
// NUM_CH:1 streaming multiplexer with a registered output stage, direct-select or round-robin grant.
// Optional MUX_N_1_STREAM_TRISTATE_EN: Data_Out floats to 'Z' while Enable_In = 0.
module mux_n_1_stream #(
   parameter  int unsigned NUM_CH = 32,
   parameter  int unsigned DATA_W = 8,
   localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
   input  logic                     Clk_In,
   input  logic                     Reset_N_In,
   input  logic                     Enable_In,
   input  logic                     Mode_In,
   input  logic [SEL_W-1:0]         Select_In,
   input  logic [NUM_CH*DATA_W-1:0] Data_In,
   input  logic [NUM_CH-1:0]        Valid_In,
   output logic [NUM_CH-1:0]        Ready_Out,
   output logic [DATA_W-1:0]        Data_Out,
   output logic [SEL_W-1:0]         Channel_Out,
   output logic                     Valid_Out,
   input  logic                     Ready_In
);

   logic                r_valid;
   logic [DATA_W-1:0]   r_data;
   logic [SEL_W-1:0]    r_chan;
   logic [SEL_W-1:0]    r_last;

   logic                w_free;
   logic                w_hit;
   logic                w_accept;
   logic [SEL_W-1:0]    w_idx;
   int unsigned         w_scan;
   logic [NUM_CH-1:0]   w_gnt;
   logic [DATA_W-1:0]   w_data;

   // Candidate channel: direct select, or first valid channel after the last grant
   always_comb begin
      w_hit  = 1'b0;
      w_idx  = '0;
      w_scan = 0;
      if (!Mode_In) begin
         if (32'(Select_In) < NUM_CH) begin
            w_hit = Valid_In[Select_In];
            w_idx = Select_In;
         end
      end else begin
         for (int unsigned i = 1; i <= NUM_CH; i++) begin
            w_scan = 32'(r_last) + i;
            if (w_scan >= NUM_CH) w_scan = w_scan - NUM_CH;
            if (!w_hit && Valid_In[SEL_W'(w_scan)]) begin
               w_hit = 1'b1;
               w_idx = SEL_W'(w_scan);
            end
         end
      end
   end

   assign w_free   = !r_valid || Ready_In;
   assign w_accept = Reset_N_In && Enable_In && w_free && w_hit;

   // One-hot grant and data selection for the candidate channel
   always_comb begin
      w_gnt  = '0;
      w_data = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (w_idx == SEL_W'(k)) begin
            w_gnt[k] = w_accept;
            w_data   = Data_In[k*DATA_W +: DATA_W];
         end
      end
   end

   assign Ready_Out = w_gnt;

   // Output register; Last_Grant resets to NUM_CH-1 so the first scan starts at channel 0
   always_ff @(posedge Clk_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_chan  <= '0;
         r_last  <= SEL_W'(NUM_CH - 1);
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_data  <= w_data;
         r_chan  <= w_idx;
         r_last  <= w_idx;
      end else if (Ready_In) begin
         r_valid <= 1'b0;
      end
   end

   assign Valid_Out   = r_valid;
   assign Channel_Out = r_chan;

`ifdef MUX_N_1_STREAM_TRISTATE_EN
   assign Data_Out = Enable_In ? r_data : 'z;
`else
   assign Data_Out = r_data;
`endif

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Self-checking bench for mux_n_1_stream: vector table, corner sequences, randomized model check.
module tb_mux_n_1_stream;

   logic         clk;
   logic         rst_n, en, mode, rin, vout;
   logic [4:0]   sel, chout;
   logic [255:0] din;
   logic [31:0]  vin, rout;
   logic [7:0]   dout;

   logic         rst_n5, en5, mode5, rin5, vout5;
   logic [2:0]   sel5, chout5;
   logic [39:0]  din5;
   logic [4:0]   vin5, rout5;
   logic [7:0]   dout5;

   int total = 0;
   int bad   = 0;

   mux_n_1_stream #(.NUM_CH(32), .DATA_W(8)) dut (
      .Clk_In(clk), .Reset_N_In(rst_n), .Enable_In(en), .Mode_In(mode),
      .Select_In(sel), .Data_In(din), .Valid_In(vin), .Ready_Out(rout),
      .Data_Out(dout), .Channel_Out(chout), .Valid_Out(vout), .Ready_In(rin)
   );

   mux_n_1_stream #(.NUM_CH(5), .DATA_W(8)) dut5 (
      .Clk_In(clk), .Reset_N_In(rst_n5), .Enable_In(en5), .Mode_In(mode5),
      .Select_In(sel5), .Data_In(din5), .Valid_In(vin5), .Ready_Out(rout5),
      .Data_Out(dout5), .Channel_Out(chout5), .Valid_Out(vout5), .Ready_In(rin5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic [4:0]  sel;
      logic [31:0] valid;
      logic        en;
      logic        rdy;
      logic [31:0] exp_ready;
      logic        exp_vout;
      logic [4:0]  exp_chan;
   } vec_t;

   vec_t tbl[14];

   // reference state
   logic       m_valid;
   logic [7:0] m_data;
   logic [4:0] m_chan;
   int         m_last;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] shown(input logic [7:0] d, input logic e);
`ifdef MUX_N_1_STREAM_TRISTATE_EN
      return e ? d : 8'bz;
`else
      return (e === 1'bx) ? d : d;
`endif
   endfunction

   // Grant rule: nothing unless enabled and output free; direct picks Select_In,
   // round-robin takes the first valid channel after the previous grant, wrapping.
   function automatic int exp_grant(input logic md, input logic [4:0] s, input logic [31:0] v,
                                    input logic e, input logic fr, input int last);
      if (!e || !fr) return -1;
      if (!md) return v[s] ? int'(s) : -1;
      for (int off = 1; off <= 32; off++)
         if (v[(last + off) % 32]) return (last + off) % 32;
      return -1;
   endfunction

   task automatic pattern_data();
      for (int k = 0; k < 32; k++) din[k*8 +: 8] = 8'hA0 | 8'(k);
   endtask

   task automatic reset_main();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_valid = 1'b0; m_data = 8'h00; m_chan = 5'd0; m_last = 31;
   endtask

   // One model-checked cycle: inputs already driven just after a falling edge
   task automatic model_cycle();
      int g;
      logic [31:0] er;
      #1;
      g  = exp_grant(mode, sel, vin, en, !m_valid || rin, m_last);
      er = (g < 0) ? 32'h0 : (32'h1 << g);
      chk("rand_ready_out", 64'(rout), 64'(er));
      @(posedge clk);
      if (g >= 0) begin
         m_valid = 1'b1; m_data = din[g*8 +: 8]; m_chan = 5'(g); m_last = g;
      end else if (rin) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
      chk("rand_valid_out", 64'(vout), 64'(m_valid));
      chk("rand_chan_out", 64'(chout), 64'(m_chan));
      chk("rand_data_out", 64'(dout), 64'(shown(m_data, en)));
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 5'd0; vin = 32'hFFFF_FFFF; rin = 1'b1;
      rst_n5 = 1'b0; en5 = 1'b1; mode5 = 1'b0; sel5 = 3'd0; vin5 = 5'h00; rin5 = 1'b1;
      for (int k = 0; k < 5; k++) din5[k*8 +: 8] = 8'h50 + 8'(k);
      pattern_data();

      tbl[0]  = '{1'b0, 5'd5,  32'h0000_0020, 1'b1, 1'b1, 32'h0000_0020, 1'b1, 5'd5};
      tbl[1]  = '{1'b0, 5'd5,  32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 5'd5};
      tbl[2]  = '{1'b0, 5'd9,  32'h0000_0220, 1'b1, 1'b0, 32'h0000_0200, 1'b1, 5'd9};
      tbl[3]  = '{1'b0, 5'd5,  32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 5'd9};
      tbl[4]  = '{1'b0, 5'd5,  32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0020, 1'b1, 5'd5};
      tbl[5]  = '{1'b0, 5'd5,  32'h0000_0020, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 5'd5};
      tbl[6]  = '{1'b1, 5'd0,  32'h4000_0008, 1'b1, 1'b1, 32'h4000_0000, 1'b1, 5'd30};
      tbl[7]  = '{1'b1, 5'd0,  32'h4000_0008, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 5'd3};
      tbl[8]  = '{1'b1, 5'd0,  32'h4000_0008, 1'b1, 1'b1, 32'h4000_0000, 1'b1, 5'd30};
      tbl[9]  = '{1'b0, 5'd31, 32'h8000_0000, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 5'd31};
      tbl[10] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 5'd0};
      tbl[11] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 5'd1};
      tbl[12] = '{1'b1, 5'd0,  32'h0000_0008, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 5'd3};
      tbl[13] = '{1'b1, 5'd0,  32'h0000_0008, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 5'd3};

      // Reset state, with every channel valid to show no grant during reset
      @(negedge clk);
      #1;
      chk("reset_ready_out", 64'(rout), 64'h0);
      chk("reset_valid_out", 64'(vout), 64'h0);
      chk("reset_data_out", 64'(dout), 64'h0);
      chk("reset_chan_out", 64'(chout), 64'h0);
      @(negedge clk);
      rst_n = 1'b1; rst_n5 = 1'b1;

      // Vector table
      for (int i = 0; i < 14; i++) begin
         mode = tbl[i].mode; sel = tbl[i].sel; vin = tbl[i].valid;
         en = tbl[i].en; rin = tbl[i].rdy;
         #1;
         chk($sformatf("vec%0d_ready_out", i), 64'(rout), 64'(tbl[i].exp_ready));
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d_valid_out", i), 64'(vout), 64'(tbl[i].exp_vout));
         chk($sformatf("vec%0d_chan_out", i), 64'(chout), 64'(tbl[i].exp_chan));
         chk($sformatf("vec%0d_data_out", i), 64'(dout),
             64'(shown(8'hA0 | 8'(tbl[i].exp_chan), tbl[i].en)));
      end

      // Round-robin, all channels valid: 0..31,0,1 from reset
      reset_main();
      mode = 1'b1; vin = 32'hFFFF_FFFF; en = 1'b1; rin = 1'b1;
      for (int i = 0; i < 34; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("rr_all_chan%0d", i), 64'(chout), 64'(i % 32));
         chk($sformatf("rr_all_valid%0d", i), 64'(vout), 64'h1);
      end

      // Backpressure: output frozen, no grant; release drains and refills same cycle
      rin = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bp_ready_out", 64'(rout), 64'h0);
         @(posedge clk);
         @(negedge clk);
         chk("bp_chan_out", 64'(chout), 64'd1);
         chk("bp_data_out", 64'(dout), 64'hA1);
         chk("bp_valid_out", 64'(vout), 64'h1);
      end
      rin = 1'b1;
      #1;
      chk("bp_release_ready", 64'(rout), 64'h4);
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_chan", 64'(chout), 64'd2);
      chk("bp_release_valid", 64'(vout), 64'h1);

      // Five-channel instance: out-of-range select, then async reset mid-stream
      sel5 = 3'd7; vin5 = 5'h1F; mode5 = 1'b0;
      #1;
      chk("n5_sel7_ready", 64'(rout5), 64'h0);
      @(posedge clk);
      @(negedge clk);
      chk("n5_sel7_valid", 64'(vout5), 64'h0);
      mode5 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("n5_rr_ready", 64'(rout5), 64'(5'h1 << i));
         @(posedge clk);
         @(negedge clk);
         chk("n5_rr_chan", 64'(chout5), 64'(i));
         chk("n5_rr_data", 64'(dout5), 64'(8'h50 + 8'(i)));
      end
      #2;
      rst_n5 = 1'b0;
      #1;
      chk("n5_async_valid", 64'(vout5), 64'h0);
      chk("n5_async_ready", 64'(rout5), 64'h0);
      @(negedge clk);
      rst_n5 = 1'b1;
      #1;
      chk("n5_post_reset_ready", 64'(rout5), 64'h1);
      @(posedge clk);
      @(negedge clk);
      chk("n5_post_reset_chan", 64'(chout5), 64'd0);
      chk("n5_post_reset_valid", 64'(vout5), 64'h1);

      // Randomized traffic against the reference model
      reset_main();
      for (int i = 0; i < 400; i++) begin
         mode = 1'($urandom_range(0, 1));
         sel  = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0:       vin = 32'h0;
            1:       vin = $urandom;
            default: vin = $urandom & $urandom & $urandom;
         endcase
         en  = ($urandom_range(0, 7) != 0);
         rin = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 8; k++) din[k*32 +: 32] = $urandom;
         model_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_n_1_stream.md
# mux_n_1_stream

Parametrised N:1 streaming multiplexer with a registered output stage and valid/ready handshakes, generalising the fixed 32:1 single-bit combinational MUX to NUM_CH channels of DATA_W bits. Runs in one of two modes: direct select, where the software-driven select picks the channel, or round-robin scan, where the block arbitrates fairly among valid channels. Sits between multiple producer streams and a single consumer in data-selector and converter datapaths.

## Interface
- NUM_CH, 32, number of input channels (2..256)
- DATA_W, 8, bits per channel
- SEL_W (localparam), $clog2(NUM_CH), select and channel-index width
- Clk_In  input  1  single clock, rising edge
- Reset_N_In  input  1  reset, asynchronous assert, active-low
- Enable_In  input  1  1 = block may accept new data; 0 = no new grants
- Mode_In  input  1  0 = direct select, 1 = round-robin scan
- Select_In  input  SEL_W  channel index used in direct mode
- Data_In  input  NUM_CH*DATA_W  packed channels; channel k = bits [k*DATA_W +: DATA_W]
- Valid_In  input  NUM_CH  per-channel valid
- Ready_Out  output  NUM_CH  one-hot grant; channel k transfers when Valid_In[k] && Ready_Out[k]
- Data_Out  output  DATA_W  registered selected data
- Channel_Out  output  SEL_W  index of the channel that supplied Data_Out
- Valid_Out  output  1  Data_Out holds an unconsumed word
- Ready_In  input  1  consumer ready; transfer when Valid_Out && Ready_In

## Operation
- Output register is free when Valid_Out = 0 or Ready_In = 1 (same-cycle drain and refill allowed).
- Grant is combinational: Ready_Out[k] = 1 only when Enable_In = 1, output register free, and k is the chosen channel; at most one bit set.
- Direct mode: chosen channel = Select_In if Select_In < NUM_CH and Valid_In[Select_In] = 1; otherwise no grant.
- Select_In >= NUM_CH (non-power-of-two NUM_CH): no grant, no data loss, Valid_Out unaffected except by drain.
- Round-robin mode: chosen channel = first k with Valid_In[k] = 1 scanning Last_Grant+1, Last_Grant+2, … with wrap at NUM_CH-1 -> 0; Last_Grant itself is last priority.
- Last_Grant updates to the granted index on every accepted transfer in either mode; it is retained across mode switches.
- On accept: Data_Out <= channel data, Channel_Out <= index, Valid_Out <= 1.
- On drain without accept: Valid_Out <= 0; Data_Out and Channel_Out hold last value.
- Enable_In = 0: no grants; a word already held in the output register stays valid and drains normally.
- Mode_In and Select_In are sampled combinationally each cycle; changes take effect on the same cycle's grant.

## Timing
- Reset (Reset_N_In = 0, asynchronous): Valid_Out = 0, Data_Out = 0, Channel_Out = 0, Last_Grant = NUM_CH-1 (first round-robin scan starts at channel 0); Ready_Out = 0 while in reset.
- Reset mid-transfer: held word discarded; no grant in any cycle Reset_N_In is low.
- Latency: accepted input appears on Data_Out/Valid_Out one cycle after the grant edge.
- Throughput: one word per cycle when Ready_In held 1.
- Backpressure: Ready_In = 0 with Valid_Out = 1 freezes Data_Out/Channel_Out and forces Ready_Out = 0.
- Round-robin with all NUM_CH channels permanently valid: grants cycle 0,1,…,NUM_CH-1,0 with no repeats.

## Configuration
- MUX_N_1_STREAM_TRISTATE_EN defined: Data_Out is driven 'Z' whenever Enable_In = 0 (legacy bus-sharing behaviour); internal register contents kept.
- Not defined: Data_Out always driven from the output register regardless of Enable_In.

## Test plan
- Reset then direct mode, Select_In = 5, Valid_In[5] = 1, Data ch5 = 8'hA5, Ready_In = 1 -> Ready_Out = 32'h20 that cycle; next cycle Data_Out = 8'hA5, Channel_Out = 5, Valid_Out = 1.
- Round-robin, Valid_In = all 1, Ready_In = 1 for 34 cycles -> Channel_Out sequence 0..31,0,1.
- Round-robin, only channels 3 and 30 valid -> grants alternate 3,30,3,30; after dropping ch30, grants 3 every cycle.
- Ready_In = 0 for 4 cycles with Valid_Out = 1 -> Data_Out frozen, Ready_Out = 0; on Ready_In = 1 same-cycle drain and new accept.
- NUM_CH = 5 instance, Select_In = 7 -> Ready_Out = 0, Valid_Out stays 0; Reset_N_In pulsed low mid-stream -> Valid_Out = 0 asynchronously, next round-robin grant is channel 0.
- With MUX_N_1_STREAM_TRISTATE_EN, Enable_In = 0 -> Data_Out = 'Z', no grants; without macro Data_Out holds last value.
